// File: rtl/ascon_seq.sv
// Sequencer driving one external ASCON AEAD core through init, N_AD associated-data
// blocks, N_PT plaintext blocks (last one with finalisation) and tag capture.
module ascon_seq #(
  parameter int N_PT = 23,
  parameter int N_AD = 1
) (
  input  logic                 clock_i,
  input  logic                 resetb_i,
  input  logic                 start_i,
  input  logic [64*N_PT-1:0]   plain_text_i,
  input  logic [64*N_AD-1:0]   da_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [64*N_PT-1:0]   cipher_o,
  output logic [127:0]         tag_o,
  output logic                 init_o,
  output logic                 associate_data_o,
  output logic                 finalisation_o,
  output logic                 data_valid_o,
  output logic [63:0]          data_o,
  input  logic                 end_initialisation_i,
  input  logic                 end_associate_i,
  input  logic                 cipher_valid_i,
  input  logic                 end_cipher_i,
  input  logic                 end_tag_i,
  input  logic [63:0]          cipher_i,
  input  logic [127:0]         tag_i
);

  localparam int AW = $clog2(N_AD) + 1;
  localparam int PW = $clog2(N_PT) + 1;

  typedef enum logic [3:0] {
    IDLE, INIT, INIT_WAIT, AD_SEND, AD_WAIT,
    PT_SEND, PT_WAIT, FIN_SEND, FIN_WAIT, DONE
  } state_t;

  state_t          state;
  logic [AW-1:0]   ad_cnt;
  logic [PW-1:0]   pt_cnt;
  logic [63:0]     pt_blk    [N_PT];
  logic [63:0]     ad_blk    [N_AD];
  logic [63:0]     cipher_q  [N_PT];
  logic [63:0]     pt_sel;
  logic [63:0]     ad_sel;
  logic            start_accept;
  logic            cap_pt;
  logic            cap_fin;
  logic            pt_more;

  // Block 0 sits in the MSBs of each wide bus.
  for (genvar gi = 0; gi < N_PT; gi++) begin : g_pt
    assign pt_blk[gi] = plain_text_i[64*(N_PT-gi)-1 -: 64];
    assign cipher_o[64*(N_PT-gi)-1 -: 64] = cipher_q[gi];
  end

  for (genvar gi = 0; gi < N_AD; gi++) begin : g_ad
    assign ad_blk[gi] = da_i[64*(N_AD-gi)-1 -: 64];
  end

  always_comb begin
    pt_sel = '0;
    for (int i = 0; i < N_PT; i++) begin
      if (int'(pt_cnt) == i) pt_sel = pt_blk[i];
    end
  end

  always_comb begin
    ad_sel = '0;
    for (int i = 0; i < N_AD; i++) begin
      if (int'(ad_cnt) == i) ad_sel = ad_blk[i];
    end
  end

  assign start_accept = (state == IDLE) && start_i;
  assign cap_pt       = (state == PT_SEND) && cipher_valid_i;
  assign cap_fin      = (state == FIN_SEND) && cipher_valid_i;
  assign pt_more      = int'(pt_cnt) < N_PT - 2;

  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      state  <= IDLE;
      ad_cnt <= '0;
      pt_cnt <= '0;
      tag_o  <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          state  <= INIT;
          ad_cnt <= '0;
          pt_cnt <= '0;
          tag_o  <= '0;
        end
        INIT:      state <= INIT_WAIT;
        INIT_WAIT: if (end_initialisation_i) state <= AD_SEND;
        AD_SEND:   state <= AD_WAIT;
        AD_WAIT: if (end_associate_i) begin
          if (int'(ad_cnt) < N_AD - 1) begin
            ad_cnt <= ad_cnt + 1'b1;
            state  <= AD_SEND;
          end else begin
            state <= (N_PT > 1) ? PT_SEND : FIN_SEND;
          end
        end
        // A core that finishes a block in the same cycle it accepts it skips PT_WAIT.
        PT_SEND: if (cipher_valid_i) begin
          if (end_cipher_i) begin
            if (pt_more) begin
              pt_cnt <= pt_cnt + 1'b1;
              state  <= PT_SEND;
            end else begin
              state <= FIN_SEND;
            end
          end else begin
            state <= PT_WAIT;
          end
        end
        PT_WAIT: if (end_cipher_i) begin
          if (pt_more) begin
            pt_cnt <= pt_cnt + 1'b1;
            state  <= PT_SEND;
          end else begin
            state <= FIN_SEND;
          end
        end
        FIN_SEND: if (cipher_valid_i) state <= FIN_WAIT;
        FIN_WAIT: if (end_tag_i) begin
          state <= DONE;
          tag_o <= tag_i;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    for (int i = 0; i < N_PT; i++) begin
      if (!resetb_i || start_accept) begin
        cipher_q[i] <= '0;
      end else if ((cap_pt && int'(pt_cnt) == i) || (cap_fin && i == N_PT - 1)) begin
        cipher_q[i] <= cipher_i;
      end
    end
  end

  always_comb begin
    busy_o           = (state != IDLE);
    done_o           = (state == DONE);
    init_o           = (state == INIT);
    associate_data_o = (state == AD_SEND);
    finalisation_o   = (state == FIN_SEND);
    data_valid_o     = (state == AD_SEND) || (state == PT_SEND) || (state == FIN_SEND);
    case (state)
      AD_SEND:  data_o = ad_sel;
      PT_SEND:  data_o = pt_sel;
      FIN_SEND: data_o = pt_blk[N_PT-1];
      default:  data_o = '0;
    endcase
  end

endmodule

// File: tb/tb_ascon_seq.sv
// Directed bench for ascon_seq: two instances (23/1 and 1/3 blocks) each paired
// with a small ideal-core model that returns cipher = data ^ A5.. and a fixed tag.
module tb_ascon_seq;

  localparam logic [63:0]  KEYX = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [127:0] TAGC = 128'h0123456789ABCDEF0123456789ABCDEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // ---------------- instance A: N_PT=23, N_AD=1 ----------------
  logic            resetb_a, start_a, busy_a, done_a;
  logic [1471:0]   plain_a, cipher_a;
  logic [63:0]     da_a, data_a, ci_a;
  logic [127:0]    tag_a;
  logic            init_a, assoc_a, fin_a, dv_a;
  logic            ei_a, ea_a, ecr_a, et_a, cv_a, ec_a;
  logic            fast_a, spur_a;

  ascon_seq #(.N_PT(23), .N_AD(1)) dut_a (
    .clock_i(clk), .resetb_i(resetb_a), .start_i(start_a),
    .plain_text_i(plain_a), .da_i(da_a),
    .busy_o(busy_a), .done_o(done_a), .cipher_o(cipher_a), .tag_o(tag_a),
    .init_o(init_a), .associate_data_o(assoc_a), .finalisation_o(fin_a),
    .data_valid_o(dv_a), .data_o(data_a),
    .end_initialisation_i(ei_a), .end_associate_i(ea_a), .cipher_valid_i(cv_a),
    .end_cipher_i(ec_a), .end_tag_i(et_a), .cipher_i(ci_a), .tag_i(TAGC)
  );

  always @(posedge clk) begin
    if (!resetb_a) begin
      ei_a <= 1'b0; ea_a <= 1'b0; ecr_a <= 1'b0; et_a <= 1'b0;
    end else begin
      ei_a  <= init_a;
      ea_a  <= assoc_a;
      ecr_a <= dv_a && !assoc_a && !fin_a;
      et_a  <= dv_a && fin_a;
    end
  end
  // spur_a raises cipher_valid in every non-sending state; it must never be captured.
  assign cv_a = (dv_a && !assoc_a) || (spur_a && !dv_a);
  assign ec_a = fast_a ? (dv_a && !assoc_a && !fin_a) : ecr_a;
  assign ci_a = data_a ^ KEYX;

  // ---------------- instance B: N_PT=1, N_AD=3 ----------------
  logic            resetb_b, start_b, busy_b, done_b;
  logic [63:0]     plain_b, cipher_b, data_b, ci_b;
  logic [191:0]    da_b;
  logic [127:0]    tag_b;
  logic            init_b, assoc_b, fin_b, dv_b;
  logic            ei_b, ea_b, ec_b, et_b, cv_b;

  ascon_seq #(.N_PT(1), .N_AD(3)) dut_b (
    .clock_i(clk), .resetb_i(resetb_b), .start_i(start_b),
    .plain_text_i(plain_b), .da_i(da_b),
    .busy_o(busy_b), .done_o(done_b), .cipher_o(cipher_b), .tag_o(tag_b),
    .init_o(init_b), .associate_data_o(assoc_b), .finalisation_o(fin_b),
    .data_valid_o(dv_b), .data_o(data_b),
    .end_initialisation_i(ei_b), .end_associate_i(ea_b), .cipher_valid_i(cv_b),
    .end_cipher_i(ec_b), .end_tag_i(et_b), .cipher_i(ci_b), .tag_i(TAGC)
  );

  always @(posedge clk) begin
    if (!resetb_b) begin
      ei_b <= 1'b0; ea_b <= 1'b0; ec_b <= 1'b0; et_b <= 1'b0;
    end else begin
      ei_b <= init_b;
      ea_b <= assoc_b;
      ec_b <= dv_b && !assoc_b && !fin_b;
      et_b <= dv_b && fin_b;
    end
  end
  assign cv_b = dv_b && !assoc_b;
  assign ci_b = data_b ^ KEYX;

  // ---------------- helpers (stimulus only) ----------------
  function automatic logic [63:0] pt_word(input int seed, input int k);
    logic [31:0] s;
    s = seed;
    return {s[15:0], 16'hC0DE, 16'(k * 3 + 1), 16'(k)};
  endfunction

  task automatic fill_a(input int seed);
    for (int k = 0; k < 23; k++) plain_a[64*(23-k)-1 -: 64] = pt_word(seed, k);
  endtask

  // Launches one run on instance A; pulse_at>=0 re-asserts start that many cycles in.
  task automatic run_a(input int pulse_at, output int n, output int n_done,
                       output int n_init, output logic init_first, output logic busy_after);
    n = 0; n_done = 0; n_init = 0; busy_after = 1'b1;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    init_first = init_a;
    if (init_a) n_init++;
    while (!done_a && n < 200) begin
      @(negedge clk);
      n++;
      start_a = (n == pulse_at);
      if (init_a) n_init++;
      if (done_a) n_done++;
    end
    start_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) busy_after = busy_a;
      if (done_a) n_done++;
      if (init_a) n_init++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetb_a = 1'b0; resetb_b = 1'b0; start_a = 1'b1; start_b = 1'b1;
    repeat (3) @(negedge clk);
    $display("reset: held 3 cycles with start high");
    checks++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy_a: got %b expected 0", busy_a); end
    checks++; if (done_a !== 1'b0) begin fails++; $display("FAIL reset_done_a: got %b expected 0", done_a); end
    checks++; if (cipher_a !== '0) begin fails++; $display("FAIL reset_cipher_a: nonzero, expected 0"); end
    checks++; if (tag_a !== '0) begin fails++; $display("FAIL reset_tag_a: got %h expected 0", tag_a); end
    checks++; if ({init_a, assoc_a, fin_a, dv_a} !== 4'b0) begin fails++;
      $display("FAIL reset_ctrl_a: got %b expected 0000", {init_a, assoc_a, fin_a, dv_a}); end
    checks++; if (data_a !== '0) begin fails++; $display("FAIL reset_data_a: got %h expected 0", data_a); end
    checks++; if ({busy_b, done_b, init_b, dv_b} !== 4'b0) begin fails++;
      $display("FAIL reset_b_flags: got %b expected 0000", {busy_b, done_b, init_b, dv_b}); end
    checks++; if ({cipher_b, tag_b} !== '0) begin fails++; $display("FAIL reset_b_regs: nonzero, expected 0"); end
    start_a = 1'b0; start_b = 1'b0;
    @(negedge clk);
    resetb_a = 1'b1; resetb_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_blocks_a(input int seed, input string tag);
    for (int k = 0; k < 23; k++) begin
      checks++;
      if (cipher_a[64*(23-k)-1 -: 64] !== (pt_word(seed, k) ^ KEYX)) begin
        fails++;
        $display("FAIL %s_blk%0d: got %h expected %h", tag, k,
                 cipher_a[64*(23-k)-1 -: 64], pt_word(seed, k) ^ KEYX);
      end
    end
  endtask

  task automatic test_default_run();
    int n, nd, ni;
    logic f, b;
    fast_a = 1'b0; spur_a = 1'b1; fill_a(1);
    run_a(-1, n, nd, ni, f, b);
    $display("default run: cycles=%0d dones=%0d inits=%0d tag=%h", n, nd, ni, tag_a);
    checks++; if (n !== 50) begin fails++; $display("FAIL default_cycles: got %0d expected 50", n); end
    checks++; if (nd !== 1) begin fails++; $display("FAIL default_done_pulses: got %0d expected 1", nd); end
    checks++; if (ni !== 1 || f !== 1'b1) begin fails++;
      $display("FAIL default_init: got count %0d first %b expected 1 1", ni, f); end
    checks++; if (b !== 1'b0) begin fails++; $display("FAIL default_busy_fall: got %b expected 0", b); end
    checks++; if (tag_a !== TAGC) begin fails++; $display("FAIL default_tag: got %h expected %h", tag_a, TAGC); end
    checks++; if (cipher_a[1471:1408] !== (pt_word(1, 0) ^ KEYX)) begin fails++;
      $display("FAIL default_msb_block: got %h expected %h", cipher_a[1471:1408], pt_word(1, 0) ^ KEYX); end
    check_blocks_a(1, "default");
    spur_a = 1'b0;
  endtask

  task automatic test_same_cycle_end();
    int n, nd, ni;
    logic f, b;
    fast_a = 1'b1; fill_a(2);
    run_a(-1, n, nd, ni, f, b);
    $display("same-cycle end run: cycles=%0d dones=%0d", n, nd);
    checks++; if (n !== 28) begin fails++; $display("FAIL fast_cycles: got %0d expected 28", n); end
    checks++; if (nd !== 1) begin fails++; $display("FAIL fast_done_pulses: got %0d expected 1", nd); end
    checks++; if (tag_a !== TAGC) begin fails++; $display("FAIL fast_tag: got %h expected %h", tag_a, TAGC); end
    check_blocks_a(2, "fast");
    fast_a = 1'b0;
  endtask

  task automatic test_start_while_busy();
    int n, nd, ni;
    logic f, b;
    fill_a(3);
    run_a(20, n, nd, ni, f, b);
    $display("start mid-run: cycles=%0d dones=%0d inits=%0d", n, nd, ni);
    checks++; if (n !== 50) begin fails++; $display("FAIL busy_start_cycles: got %0d expected 50", n); end
    checks++; if (nd !== 1) begin fails++; $display("FAIL busy_start_dones: got %0d expected 1", nd); end
    checks++; if (ni !== 1) begin fails++; $display("FAIL busy_start_inits: got %0d expected 1", ni); end
    check_blocks_a(3, "busy_start");
  endtask

  task automatic test_reset_mid_run();
    int n, nd, ni;
    logic f, b;
    fill_a(4);
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    repeat (15) @(negedge clk);
    // Now in PT_WAIT for block 5; block 5 was captured on the previous edge.
    checks++; if ({busy_a, dv_a} !== 2'b10) begin fails++;
      $display("FAIL midreset_pt_wait: got busy/dv %b expected 10", {busy_a, dv_a}); end
    checks++; if (cipher_a[64*18-1 -: 64] !== (pt_word(4, 5) ^ KEYX)) begin fails++;
      $display("FAIL midreset_blk5: got %h expected %h", cipher_a[64*18-1 -: 64], pt_word(4, 5) ^ KEYX); end
    resetb_a = 1'b0;
    @(negedge clk);
    $display("reset in PT_WAIT block 5: busy=%b", busy_a);
    checks++; if (busy_a !== 1'b0) begin fails++; $display("FAIL midreset_busy: got %b expected 0", busy_a); end
    checks++; if (cipher_a !== '0) begin fails++; $display("FAIL midreset_cipher: nonzero, expected 0"); end
    checks++; if ({init_a, assoc_a, fin_a, dv_a, data_a} !== '0) begin fails++;
      $display("FAIL midreset_ctrl: data %h ctrl %b expected 0", data_a, {init_a, assoc_a, fin_a, dv_a}); end
    resetb_a = 1'b1;
    fill_a(5);
    run_a(-1, n, nd, ni, f, b);
    $display("fresh run after reset: cycles=%0d dones=%0d", n, nd);
    checks++; if (n !== 50 || nd !== 1) begin fails++;
      $display("FAIL postreset_run: got cycles %0d dones %0d expected 50 1", n, nd); end
    checks++; if (tag_a !== TAGC) begin fails++; $display("FAIL postreset_tag: got %h expected %h", tag_a, TAGC); end
    check_blocks_a(5, "postreset");
  endtask

  task automatic test_single_pt_three_ad();
    logic [63:0] ad_exp [3];
    int n, ad_i, pt_sends, fin_seen;
    ad_exp[0] = 64'hDA00_0000_0000_0001;
    ad_exp[1] = 64'hDA00_0000_0000_0002;
    ad_exp[2] = 64'hDA00_0000_0000_0003;
    da_b = {ad_exp[0], ad_exp[1], ad_exp[2]};
    plain_b = 64'h0011_2233_4455_6677;
    n = 0; ad_i = 0; pt_sends = 0; fin_seen = 0;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    while (!done_b && n < 100) begin
      if (assoc_b) begin
        checks++;
        if (ad_i > 2 || data_b !== ad_exp[ad_i > 2 ? 2 : ad_i] || dv_b !== 1'b1) begin
          fails++;
          $display("FAIL ad_block%0d: got data %h dv %b", ad_i, data_b, dv_b);
        end
        ad_i++;
      end
      if (dv_b && !assoc_b && !fin_b) pt_sends++;
      if (fin_b) begin
        fin_seen++;
        checks++;
        if (data_b !== plain_b) begin fails++;
          $display("FAIL fin_data: got %h expected %h", data_b, plain_b); end
      end
      @(negedge clk);
      n++;
    end
    $display("N_PT=1 N_AD=3 run: cycles=%0d ad_pulses=%0d pt_sends=%0d fin=%0d", n, ad_i, pt_sends, fin_seen);
    checks++; if (n !== 10) begin fails++; $display("FAIL small_cycles: got %0d expected 10", n); end
    checks++; if (ad_i !== 3) begin fails++; $display("FAIL small_ad_pulses: got %0d expected 3", ad_i); end
    checks++; if (pt_sends !== 0 || fin_seen !== 1) begin fails++;
      $display("FAIL small_path: got pt_sends %0d fin %0d expected 0 1", pt_sends, fin_seen); end
    checks++; if (cipher_b !== 64'hA5B4_8796_E1F0_C3D2) begin fails++;
      $display("FAIL small_cipher: got %h expected a5b48796e1f0c3d2", cipher_b); end
    checks++; if (tag_b !== TAGC) begin fails++; $display("FAIL small_tag: got %h expected %h", tag_b, TAGC); end
    @(negedge clk);
  endtask

  initial begin
    resetb_a = 1'b0; resetb_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
    fast_a = 1'b0; spur_a = 1'b0;
    plain_a = '0; da_a = 64'hDA7A_0000_1111_2222;
    plain_b = '0; da_b = '0;
    test_reset();
    test_default_run();
    test_same_cycle_end();
    test_start_while_busy();
    test_reset_mid_run();
    test_single_pt_three_ad();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
